// File: rtl/usr_pkg.sv
// Shared mode codes, FSM states and mode classification for the burst shifter.
// Pure declarations; no timing or flow-control behaviour of its own.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Modes that run as a counted burst; LOAD, HOLD and reserved finish in one edge.
  function automatic logic is_step_mode(input logic [2:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
           (m == MODE_ROL) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/universal_sr_step.sv
// Single-step shifter: computes one shift/rotate/load result from the current value.
// Purely combinational, zero latency; no flow control.
module universal_sr_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] Q,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] M,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] next_Q
);
  import usr_pkg::*;

  always_comb begin
    next_Q = Q;
    case (mode)
      MODE_SHR:  next_Q = {sin_l, Q[WIDTH-1:1]};
      MODE_SHL:  next_Q = {Q[WIDTH-2:0], sin_r};
      MODE_LOAD: next_Q = M;
      MODE_ROR:  next_Q = {Q[0], Q[WIDTH-1:1]};
      MODE_ROL:  next_Q = {Q[WIDTH-2:0], Q[WIDTH-1]};
      MODE_ASR:  next_Q = {Q[WIDTH-1], Q[WIDTH-1:1]};
      default:   next_Q = Q;
    endcase
  end

endmodule

// File: rtl/universal_sr_burst.sv
// Universal shift register with a counted burst sequencer; one step per enabled cycle.
// Single-edge commands finish next edge; N-step bursts take N enabled cycles, en=0 stalls.
module universal_sr_burst #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] M,
  input  logic [CNT_W-1:0] cnt,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] Q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);
  import usr_pkg::*;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_mode, w_mode_nxt, w_step_mode;
  logic [CNT_W-1:0] r_rem, w_rem_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt, w_step_q;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  // While bursting, the latched mode drives the shifter so live mode changes are ignored.
  assign w_step_mode = (r_state == ST_SHIFT) ? r_mode : mode;

  universal_sr_step #(.WIDTH(WIDTH)) u_step (
    .Q      (r_q),
    .mode   (w_step_mode),
    .M      (M),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .next_Q (w_step_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_rem_nxt   = r_rem;
    w_q_nxt     = r_q;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start) begin
          if (is_step_mode(mode) && (cnt != '0)) begin
            w_mode_nxt  = mode;
            w_rem_nxt   = cnt;
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            if (mode == MODE_LOAD) w_q_nxt = w_step_q;
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        w_busy_nxt = 1'b1;
        if (en) begin
          w_q_nxt   = w_step_q;
          w_rem_nxt = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HOLD;
      r_rem   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_rem   <= w_rem_nxt;
      r_q     <= w_q_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign Q      = r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_universal_sr_burst.sv
// Bench for universal_sr_burst (WIDTH=8): directed scenarios plus a randomized burst run
// checked against an arithmetic step model.
module tb_universal_sr_burst;

  logic       clk = 1'b0;
  logic       clr, en, start, sin_l, sin_r;
  logic [2:0] mode;
  logic [7:0] M;
  logic [3:0] cnt;
  logic [7:0] Q;
  logic       sout_l, sout_r, busy, done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  universal_sr_burst #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .en(en), .start(start), .mode(mode), .M(M), .cnt(cnt),
    .sin_l(sin_l), .sin_r(sin_r), .Q(Q), .sout_l(sout_l), .sout_r(sout_r),
    .busy(busy), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_step(input logic [7:0] q, input logic [2:0] md,
                                          input logic sl, input logic sr);
    case (md)
      3'd1:    return (q >> 1) | ({7'd0, sl} << 7);
      3'd2:    return (q << 1) | {7'd0, sr};
      3'd4:    return (q >> 1) | (q << 7);
      3'd5:    return (q << 1) | (q >> 7);
      3'd6:    return 8'($signed(q) >>> 1);
      default: return q;
    endcase
  endfunction

  task automatic test_reset;
    int seen;
    clr = 1'b1; tick; tick;
    n_cmp++; if (Q !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h want 00", Q); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    clr = 1'b0; mode = 3'b011; M = 8'hA5; start = 1'b1; tick; start = 1'b0;
    n_cmp++; if (Q !== 8'hA5) begin n_fail++; $display("FAIL reset_preload got %h want a5", Q); end
    tick;
    clr = 1'b1; tick; clr = 1'b0;
    n_cmp++; if (Q !== 8'h00) begin n_fail++; $display("FAIL reset_idle_q got %h want 00", Q); end
    // abort a burst midway and confirm no completion pulse ever follows
    mode = 3'b011; M = 8'h5A; start = 1'b1; tick;
    mode = 3'b001; cnt = 4'd6; en = 1'b1; sin_l = 1'b0; tick; start = 1'b0;
    tick; tick;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_midburst_busy got %b want 1", busy); end
    clr = 1'b1; tick; clr = 1'b0;
    n_cmp++; if (Q !== 8'h00) begin n_fail++; $display("FAIL reset_abort_q got %h want 00", Q); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_abort_busy got %b want 0", busy); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL reset_no_done got %0d pulses want 0", seen); end
  endtask

  task automatic test_load;
    mode = 3'b011; M = 8'hB4; start = 1'b1; tick; start = 1'b0; M = 8'h00;
    n_cmp++; if (Q !== 8'hB4) begin n_fail++; $display("FAIL load_q got %h want b4", Q); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL load_done got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_busy got %b want 0", busy); end
    tick;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL load_done_drop got %b want 0", done); end
    n_cmp++; if (Q !== 8'hB4) begin n_fail++; $display("FAIL load_hold got %h want b4", Q); end
  endtask

  task automatic test_shr;
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'hDA; exp_seq[1] = 8'hED; exp_seq[2] = 8'hF6;
    mode = 3'b001; cnt = 4'd3; sin_l = 1'b1; en = 1'b1; start = 1'b1; tick;
    start = 1'b0; mode = 3'b011;
    n_cmp++; if (busy !== 1'b1 || Q !== 8'hB4) begin
      n_fail++; $display("FAIL shr_accept got busy=%b q=%h want busy=1 q=b4", busy, Q);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (Q !== exp_seq[i] || busy !== (i < 2) || done !== (i == 2)) begin
        n_fail++;
        $display("FAIL shr_step%0d got q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                 i, Q, busy, done, exp_seq[i], (i < 2), (i == 2));
      end
    end
    tick;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL shr_done_drop got %b want 0", done); end
  endtask

  task automatic test_rol_wrap;
    logic [7:0] exp_q;
    int busy_cycles;
    mode = 3'b011; M = 8'h81; start = 1'b1; tick;
    mode = 3'b101; cnt = 4'd9; en = 1'b1; tick; start = 1'b0;
    exp_q = 8'h81; busy_cycles = 0;
    for (int k = 1; k <= 9; k++) begin
      if (busy === 1'b1) busy_cycles++;
      tick;
      exp_q = ref_step(exp_q, 3'd5, 1'b0, 1'b0);
      n_cmp++; if (Q !== exp_q || sout_l !== exp_q[7] || sout_r !== exp_q[0]) begin
        n_fail++;
        $display("FAIL rol_step%0d got q=%h sl=%b sr=%b want q=%h", k, Q, sout_l, sout_r, exp_q);
      end
    end
    n_cmp++; if (Q !== 8'h03 || done !== 1'b1) begin
      n_fail++; $display("FAIL rol_final got q=%h done=%b want q=03 done=1", Q, done);
    end
    n_cmp++; if (busy_cycles !== 9) begin
      n_fail++; $display("FAIL rol_busy_len got %0d want 9", busy_cycles);
    end
    tick;
  endtask

  task automatic test_stall;
    mode = 3'b011; M = 8'h90; start = 1'b1; tick;
    mode = 3'b110; cnt = 4'd2; en = 1'b1; tick; start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || Q !== 8'h90) begin
      n_fail++; $display("FAIL stall_accept got busy=%b q=%h want busy=1 q=90", busy, Q);
    end
    tick;
    n_cmp++; if (Q !== 8'hC8) begin n_fail++; $display("FAIL stall_step1 got %h want c8", Q); end
    en = 1'b0; start = 1'b1; mode = 3'b011; M = 8'hFF; tick;
    n_cmp++; if (Q !== 8'hC8 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold got q=%h busy=%b done=%b want q=c8 busy=1 done=0", Q, busy, done);
    end
    start = 1'b0; en = 1'b1; tick;
    n_cmp++; if (Q !== 8'hE4 || busy !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL stall_final got q=%h busy=%b done=%b want q=e4 busy=0 done=1", Q, busy, done);
    end
    tick;
    n_cmp++; if (Q !== 8'hE4 || done !== 1'b0) begin
      n_fail++; $display("FAIL stall_after got q=%h done=%b want q=e4 done=0", Q, done);
    end
  endtask

  task automatic test_degenerate;
    mode = 3'b010; cnt = 4'd0; start = 1'b1; tick; start = 1'b0;
    n_cmp++; if (Q !== 8'hE4 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL degen_shl0 got q=%h done=%b busy=%b want q=e4 done=1 busy=0", Q, done, busy);
    end
    tick;
    mode = 3'b111; cnt = 4'd5; start = 1'b1; tick; start = 1'b0;
    n_cmp++; if (Q !== 8'hE4 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL degen_rsvd got q=%h done=%b busy=%b want q=e4 done=1 busy=0", Q, done, busy);
    end
    tick;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL degen_after got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    mode = 3'b011; M = 8'h3C; start = 1'b1; tick;
    mode = 3'b100; cnt = 4'd2; en = 1'b1; tick; start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || Q !== 8'h3C) begin
      n_fail++; $display("FAIL b2b_accept got busy=%b q=%h want busy=1 q=3c", busy, Q);
    end
    tick; tick;
    n_cmp++; if (Q !== 8'h0F || done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_final got q=%h done=%b want q=0f done=1", Q, done);
    end
    tick;
  endtask

  task automatic test_random;
    logic [7:0] exp_q, mv;
    logic [2:0] md;
    logic [3:0] c;
    logic       e, sl, sr;
    int         rem, guard;
    mode = 3'b011; M = 8'h6B; start = 1'b1; tick; start = 1'b0;
    exp_q = 8'h6B;
    n_cmp++; if (Q !== exp_q) begin n_fail++; $display("FAIL rand_seed got %h want 6b", Q); end
    for (int it = 0; it < 40; it++) begin
      md = 3'($urandom_range(0, 7)); c = 4'($urandom_range(0, 12)); mv = 8'($urandom);
      mode = md; cnt = c; M = mv; en = 1'($urandom); start = 1'b1;
      tick; start = 1'b0;
      if (md == 3'd3) exp_q = mv;
      if (md == 3'd3 || md == 3'd0 || md == 3'd7 || c == 4'd0) begin
        n_cmp++; if (Q !== exp_q || done !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_single%0d md=%0d got q=%h done=%b busy=%b want q=%h done=1 busy=0",
                   it, md, Q, done, busy, exp_q);
        end
      end else begin
        n_cmp++; if (Q !== exp_q || busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_accept%0d got q=%h busy=%b done=%b want q=%h busy=1 done=0",
                   it, Q, busy, done, exp_q);
        end
        rem = int'(c); guard = 0;
        while (rem > 0 && guard < 200) begin
          e = ($urandom_range(0, 3) != 0); sl = 1'($urandom); sr = 1'($urandom);
          en = e; sin_l = sl; sin_r = sr;
          start = 1'($urandom); mode = 3'($urandom); cnt = 4'($urandom); M = 8'($urandom);
          tick; guard++;
          if (e) begin
            exp_q = ref_step(exp_q, md, sl, sr);
            rem--;
          end
          n_cmp++;
          if (Q !== exp_q || sout_l !== exp_q[7] || sout_r !== exp_q[0] ||
              busy !== (rem > 0) || done !== (e && rem == 0)) begin
            n_fail++;
            $display("FAIL rand_step%0d md=%0d got q=%h busy=%b done=%b want q=%h busy=%b done=%b",
                     it, md, Q, busy, done, exp_q, (rem > 0), (e && rem == 0));
          end
        end
        start = 1'b0;
        if (rem > 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rand_timeout%0d got %0d steps left want 0", it, rem);
        end
      end
    end
    tick;
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; start = 1'b0; mode = 3'b000; M = 8'h00; cnt = 4'd0;
    sin_l = 1'b0; sin_r = 1'b0;
    test_reset;
    test_load;
    test_shr;
    test_rol_wrap;
    test_stall;
    test_degenerate;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
